exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline. Sits directly downstream of the ID/EXE pipeline register and consumes its outputs.
- Generates the second ALU operand (Val2) and runs the ALU.
- Owns the NZCV status register and computes the branch target.
- Registers the results into the EXE/MEM pipeline register, which feeds the MEM stage.

Parameters:
- WIDTH, 32, datapath width (pc, val_rn, val_rm, alu_res).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- freeze  in  1  hazard stall; hold EXE/MEM register and status register
- flush  in  1  insert bubble into EXE/MEM register
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  control from ID/EXE register
- exe_cmd_in  in  4  ALU command
- pc_in, val_rn_in, val_rm_in  in  32  operands; pc_in is already PC+4
- imm_in  in  1  immediate-operand flag
- shift_operand_in  in  12  shifter operand field
- signed_imm_24_in  in  24  branch offset
- dest_in  in  4  destination register
- status  out  4  current NZCV, feeds ID stage condition check
- br_taken  out  1  combinational, equals b_in
- br_addr  out  32  combinational, pc_in + (sign_extend(signed_imm_24_in) << 2)
- wb_en, mem_r_en, mem_w_en  out  1 each  registered control to MEM
- alu_res  out  32  registered ALU result / memory address
- st_val  out  32  registered val_rm_in (store data)
- dest  out  4  registered destination

Behaviour:
- Reset, rst=0 at a clock edge, all registered outputs go to 0: status=4'b0000, wb_en=mem_r_en=mem_w_en=0, alu_res=st_val=0, dest=0. Reset has priority over freeze and flush. A reset in the middle of operation discards any in-flight instruction.
- Latency: 1 cycle from the ID/EXE outputs to the EXE/MEM outputs. br_taken/br_addr are available in the same cycle.
- Priority at each edge, highest first:
  - reset
  - freeze=1: hold all registers, including status
  - flush=1: wb_en, mem_r_en, mem_w_en cleared; data fields don't-care, cleared to 0
  - otherwise: capture new values
- Status update: status <= {N,Z,C,V} when s_in=1 and neither freeze nor flush is active. Otherwise status holds.
- Val2 selection, in priority order:
  - imm_in=1: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - mem_r_en_in or mem_w_en_in: zero-extended shift_operand[11:0].
  - else: val_rm_in shifted by shift_operand[11:7], shift type shift_operand[6:5] = LSL 00 / LSR 01 / ASR 10 / ROR 11. A shift amount of 0 passes val_rm unchanged. Register-specified shifts are not supported.
- exe_cmd encoding:
  - MOV 0001: Val2
  - MVN 1001: ~Val2
  - ADD 0010: Rn+Val2; also used for LDR/STR address
  - ADC 0011: Rn+Val2+C
  - SUB 0100: Rn-Val2; also used for CMP
  - SBC 0101: Rn-Val2-(1-C)
  - AND 0110: Rn&Val2; also used for TST
  - ORR 0111: Rn|Val2
  - EOR 1000: Rn^Val2
  - any other code: result 0, flags unchanged
- Flag computation:
  - N = result[31]; Z = (result==0).
  - Arithmetic ops: C = bit 32 of the 33-bit sum. Subtraction C is NOT-borrow: Rn-Val2 is computed as Rn+~Val2+1 (SUB) or Rn+~Val2+C (SBC), and C is the carry out. V = signed overflow.
  - Logical/move ops: C and V are taken unchanged from the current status.
- All arithmetic wraps modulo 2^32.

Decomposition:
- Package arm_pkg holds:
  - exe_cmd constants (EXE_MOV … EXE_EOR)
  - shift-type constants (SH_LSL/LSR/ASR/ROR)
  - status bit indices (SR_N=3, SR_Z=2, SR_C=1, SR_V=0)
- Sub-module exe_alu (combinational): inputs exe_cmd, Rn, Val2, C_in; outputs result and NZCV. It is instantiated once.
- Val2 generation, the status register and the EXE/MEM register stay in exe_stage.

Test Plan:
- Reset: drive rst=0 for 2 cycles with wb_en_in=1 and s_in=1 -> all outputs 0 and status=0000; first capture occurs on the edge after rst=1.
- ADD with carry and V: Rn=0xFFFFFFFF, imm=1, shift_operand=0x001, exe_cmd=0010, s_in=1 -> alu_res=0 next cycle, status=0110 (Z,C). Then Rn=0x7FFFFFFF, same operand -> alu_res=0x80000000, status=1001.
- CMP/SBC: Rn=5, Val2=5 via MOV-style immediate, exe_cmd=0100, s=1 -> status=0110. Next, SBC Rn=5, Val2=3 with C=1 -> alu_res=2; with C=0 -> alu_res=1.
- Shifter:
  - val_rm=0x80000001, shift_operand={5'd1, ROR} -> MOV result 0xC0000000.
  - ASR 4 on 0x80000000 -> 0xF8000000.
  - imm with rotate field 1 and imm8 0xFF -> 0xC000003F.
- Freeze/flush: freeze=1 while new ADD with s=1 is presented -> outputs and status unchanged. flush=1 with wb_en_in=1 and mem_w_en_in=1 -> wb_en=0, mem_w_en=0, status unchanged. Reset asserted while freeze=1 -> outputs cleared.
- Branch and memory address: pc_in=0x100, imm24=0xFFFFFE, b_in=1 -> br_taken=1, br_addr=0xF8 in the same cycle. STR with Rn=0x400, shift_operand=0x010, val_rm=0xABCD -> alu_res=0x410, st_val=0xABCD, mem_w_en=1.

Source files
------------

// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pkg
// Description : Shared constants for the ARM execute stage: ALU command
//               codes, shifter type codes and NZCV status bit positions.
//               Also holds a helper that tells whether an ALU command is
//               one the ALU implements.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

  // ALU command codes
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  // Immediate-shift types
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  // Bit positions inside the 4-bit NZCV status word
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  function automatic logic is_alu_cmd(input logic [3:0] cmd);
    logic ok;
    case (cmd)
      EXE_MOV, EXE_MVN, EXE_ADD, EXE_ADC, EXE_SUB,
      EXE_SBC, EXE_AND, EXE_ORR, EXE_EOR: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage : arm_pkg
`default_nettype wire

// File: rtl/exe_alu.sv
`default_nettype none
// ============================================================================
// Module      : exe_alu
// Description : Combinational ALU of the execute stage. Computes the result
//               and the NZCV flags for one command.
// Ports       : exe_cmd   - ALU command code
//               rn        - first operand
//               val2      - second operand (from the shifter)
//               c_in      - current carry flag (ADC/SBC input, logic ops)
//               v_in      - current overflow flag (passed through on logic ops)
//               result    - ALU result
//               nzcv      - flags produced by this command
//               cmd_valid - high when exe_cmd is an implemented command
// Revision    : 1.0 - initial release
// ============================================================================
module exe_alu
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] rn,
  input  logic [WIDTH-1:0] val2,
  input  logic             c_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv,
  output logic             cmd_valid
);

  logic [WIDTH-1:0] addend;
  logic             carry_in;
  logic             arith;
  logic [WIDTH:0]   sum;

  // Subtraction is folded into the adder as rn + ~val2 + carry, so the
  // adder's carry-out is directly the ARM not-borrow flag.
  always_comb begin
    addend   = val2;
    carry_in = 1'b0;
    arith    = 1'b0;
    case (exe_cmd)
      EXE_ADD: begin arith = 1'b1; end
      EXE_ADC: begin arith = 1'b1; carry_in = c_in; end
      EXE_SUB: begin arith = 1'b1; addend = ~val2; carry_in = 1'b1; end
      EXE_SBC: begin arith = 1'b1; addend = ~val2; carry_in = c_in; end
      default: begin arith = 1'b0; end
    endcase
  end

  assign sum = {1'b0, rn} + {1'b0, addend} + {{WIDTH{1'b0}}, carry_in};

  always_comb begin
    result = '0;
    case (exe_cmd)
      EXE_MOV: result = val2;
      EXE_MVN: result = ~val2;
      EXE_ADD,
      EXE_ADC,
      EXE_SUB,
      EXE_SBC: result = sum[WIDTH-1:0];
      EXE_AND: result = rn & val2;
      EXE_ORR: result = rn | val2;
      EXE_EOR: result = rn ^ val2;
      default: result = '0;
    endcase
  end

  assign cmd_valid  = is_alu_cmd(exe_cmd);
  assign nzcv[SR_N] = result[WIDTH-1];
  assign nzcv[SR_Z] = (result == '0);
  assign nzcv[SR_C] = arith ? sum[WIDTH] : c_in;
  // Overflow: both adder inputs share a sign that differs from the result.
  assign nzcv[SR_V] = arith ? ((rn[WIDTH-1] == addend[WIDTH-1]) &&
                               (sum[WIDTH-1] != rn[WIDTH-1]))
                            : v_in;

endmodule : exe_alu
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : exe_stage
// Description : Execute stage of the 5-stage ARM pipeline. Builds Val2,
//               runs the ALU, owns the NZCV status register, computes the
//               branch target and registers results into EXE/MEM.
// Ports       : clk, rst (sync, active-low), freeze (hold), flush (bubble)
//               *_in              - ID/EXE register outputs
//               status            - current NZCV
//               br_taken, br_addr - combinational branch outputs
//               wb_en, mem_r_en, mem_w_en, alu_res, st_val, dest
//                                 - EXE/MEM register outputs
// Revision    : 1.0 - initial release
// ============================================================================
module exe_stage
  import arm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             b_in,
  input  logic             s_in,
  input  logic [3:0]       exe_cmd_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] val_rn_in,
  input  logic [WIDTH-1:0] val_rm_in,
  input  logic             imm_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm_24_in,
  input  logic [3:0]       dest_in,
  output logic [3:0]       status,
  output logic             br_taken,
  output logic [WIDTH-1:0] br_addr,
  output logic             wb_en,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] st_val,
  output logic [3:0]       dest
);

  logic [WIDTH-1:0] imm_base;
  logic [4:0]       imm_rot;
  logic [WIDTH-1:0] imm_val;
  logic [4:0]       sh_amt;
  logic [WIDTH-1:0] rm_shifted;
  logic [WIDTH-1:0] val2;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_nzcv;
  logic             alu_cmd_ok;

  // ---------------- branch target ----------------
  assign br_taken = b_in;
  assign br_addr  = pc_in + {{(WIDTH-26){signed_imm_24_in[23]}},
                             signed_imm_24_in, 2'b00};

  // ---------------- Val2 generation ----------------
  // Rotate amount is twice the 4-bit field. A shift by WIDTH yields zero,
  // so a zero rotate needs no special case.
  assign imm_base = {{(WIDTH-8){1'b0}}, shift_operand_in[7:0]};
  assign imm_rot  = {shift_operand_in[11:8], 1'b0};
  assign imm_val  = (imm_base >> imm_rot) |
                    (imm_base << (WIDTH - int'(imm_rot)));

  assign sh_amt = shift_operand_in[11:7];

  always_comb begin
    rm_shifted = val_rm_in;
    case (shift_operand_in[6:5])
      SH_LSL: rm_shifted = val_rm_in << sh_amt;
      SH_LSR: rm_shifted = val_rm_in >> sh_amt;
      SH_ASR: rm_shifted = $unsigned($signed(val_rm_in) >>> sh_amt);
      SH_ROR: rm_shifted = (val_rm_in >> sh_amt) |
                           (val_rm_in << (WIDTH - int'(sh_amt)));
      default: rm_shifted = val_rm_in;
    endcase
  end

  always_comb begin
    if (imm_in)
      val2 = imm_val;
    else if (mem_r_en_in || mem_w_en_in)
      val2 = {{(WIDTH-12){1'b0}}, shift_operand_in};
    else
      val2 = rm_shifted;
  end

  // ---------------- ALU ----------------
  exe_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .exe_cmd   (exe_cmd_in),
    .rn        (val_rn_in),
    .val2      (val2),
    .c_in      (status[SR_C]),
    .v_in      (status[SR_V]),
    .result    (alu_out),
    .nzcv      (alu_nzcv),
    .cmd_valid (alu_cmd_ok)
  );

  // ---------------- status register ----------------
  // Unimplemented commands leave the flags untouched even when s_in is set.
  always_ff @(posedge clk) begin
    if (!rst)
      status <= 4'b0000;
    else if (!freeze && !flush && s_in && alu_cmd_ok)
      status <= alu_nzcv;
  end

  // ---------------- EXE/MEM register ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_en    <= 1'b0;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      alu_res  <= '0;
      st_val   <= '0;
      dest     <= 4'd0;
    end else if (!freeze) begin
      if (flush) begin
        wb_en    <= 1'b0;
        mem_r_en <= 1'b0;
        mem_w_en <= 1'b0;
        alu_res  <= '0;
        st_val   <= '0;
        dest     <= 4'd0;
      end else begin
        wb_en    <= wb_en_in;
        mem_r_en <= mem_r_en_in;
        mem_w_en <= mem_w_en_in;
        alu_res  <= alu_out;
        st_val   <= val_rm_in;
        dest     <= dest_in;
      end
    end
  end

endmodule : exe_stage
`default_nettype wire

// File: tb/tb_exe_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_stage
// Description : Self-checking bench for exe_stage: directed scenarios then
//               random stimulus compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze, flush;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  status, dest;
  logic        br_taken, wb_en, mem_r_en, mem_w_en;
  logic [31:0] br_addr, alu_res, st_val;

  // model state (expected registered outputs)
  logic [3:0]  m_status, m_dest;
  logic        m_wb, m_mr, m_mw;
  logic [31:0] m_res, m_st;

  int checks = 0;
  int errors = 0;

  exe_stage #(.WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .freeze           (freeze),
    .flush            (flush),
    .wb_en_in         (wb_en_in),
    .mem_r_en_in      (mem_r_en_in),
    .mem_w_en_in      (mem_w_en_in),
    .b_in             (b_in),
    .s_in             (s_in),
    .exe_cmd_in       (exe_cmd_in),
    .pc_in            (pc_in),
    .val_rn_in        (val_rn_in),
    .val_rm_in        (val_rm_in),
    .imm_in           (imm_in),
    .shift_operand_in (shift_operand_in),
    .signed_imm_24_in (signed_imm_24_in),
    .dest_in          (dest_in),
    .status           (status),
    .br_taken         (br_taken),
    .br_addr          (br_addr),
    .wb_en            (wb_en),
    .mem_r_en         (mem_r_en),
    .mem_w_en         (mem_w_en),
    .alu_res          (alu_res),
    .st_val           (st_val),
    .dest             (dest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // rotate right by n using division/multiplication on a 64-bit value
  function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
    longint unsigned v, p, r;
    v = x;
    p = 64'd1 << n;
    r = (v / p) + ((v % p) << (32 - n));
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_val2(input logic imm, input logic mem,
                                         input logic [11:0] so, input logic [31:0] rm);
    longint unsigned v, p, r;
    longint s;
    int amt;
    if (imm) return m_ror({24'd0, so[7:0]}, 2 * int'(so[11:8]));
    if (mem) return {20'd0, so};
    amt = int'(so[11:7]);
    v = rm;
    p = 64'd1 << amt;
    case (so[6:5])
      2'b00: begin r = v * p; return r[31:0]; end
      2'b01: begin r = v / p; return r[31:0]; end
      2'b10: begin
        s = longint'($signed(rm));
        // floor division: SV division truncates toward zero
        if (s < 0) s = (s - longint'(p) + 1) / longint'(p);
        else       s = s / longint'(p);
        return 32'(s);
      end
      default: return m_ror(rm, amt);
    endcase
  endfunction

  // returns {update, N, Z, C, V, result}
  function automatic logic [36:0] m_alu(input logic [3:0] cmd, input logic [31:0] rn,
                                        input logic [31:0] v2, input logic [3:0] st);
    longint unsigned a, b, t;
    longint sa, sb, sr;
    int cin;
    logic c, v, ok;
    logic [31:0] res;
    a = rn; b = v2;
    sa = longint'($signed(rn)); sb = longint'($signed(v2));
    c = st[1]; v = st[0]; ok = 1'b1; res = 32'd0;
    case (cmd)
      4'b0001: res = v2;
      4'b1001: res = ~v2;
      4'b0010, 4'b0011: begin
        cin = (cmd == 4'b0011) ? int'(st[1]) : 0;
        t = a + b + longint'(cin);
        res = t[31:0];
        c = (t >= 64'h1_0000_0000);
        sr = sa + sb + longint'(cin);
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'b0100, 4'b0101: begin
        cin = (cmd == 4'b0101) ? (1 - int'(st[1])) : 0;   // borrow
        t = a - b - longint'(cin);
        res = t[31:0];
        c = (a >= b + longint'(cin));
        sr = sa - sb - longint'(cin);
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'b0110: res = rn & v2;
      4'b0111: res = rn | v2;
      4'b1000: res = rn ^ v2;
      default: ok = 1'b0;
    endcase
    return {ok, res[31], (res == 32'd0), c, v, res};
  endfunction

  // One clock: check combinational branch outputs, advance the model,
  // then check the registered outputs just after the edge.
  task automatic step();
    logic [36:0] a;
    logic [31:0] v2, exp_br;
    #1;
    exp_br = pc_in + 32'(longint'($signed(signed_imm_24_in)) * 4);
    chk("br_taken", {31'd0, br_taken}, {31'd0, b_in});
    chk("br_addr", br_addr, exp_br);
    if (!rst) begin
      m_status = 4'd0; m_wb = 0; m_mr = 0; m_mw = 0; m_res = 0; m_st = 0; m_dest = 0;
    end else if (freeze) begin
      // everything holds
    end else if (flush) begin
      m_wb = 0; m_mr = 0; m_mw = 0; m_res = 0; m_st = 0; m_dest = 0;
    end else begin
      v2 = m_val2(imm_in, mem_r_en_in | mem_w_en_in, shift_operand_in, val_rm_in);
      a  = m_alu(exe_cmd_in, val_rn_in, v2, m_status);
      m_wb = wb_en_in; m_mr = mem_r_en_in; m_mw = mem_w_en_in;
      m_res = a[31:0]; m_st = val_rm_in; m_dest = dest_in;
      if (s_in && a[36]) m_status = a[35:32];
    end
    @(posedge clk);
    #1;
    chk("status",   {28'd0, status},   {28'd0, m_status});
    chk("wb_en",    {31'd0, wb_en},    {31'd0, m_wb});
    chk("mem_r_en", {31'd0, mem_r_en}, {31'd0, m_mr});
    chk("mem_w_en", {31'd0, mem_w_en}, {31'd0, m_mw});
    chk("alu_res",  alu_res, m_res);
    chk("st_val",   st_val,  m_st);
    chk("dest",     {28'd0, dest},     {28'd0, m_dest});
  endtask

  task automatic defaults();
    rst = 1; freeze = 0; flush = 0;
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0; imm_in = 0;
    exe_cmd_in = 4'd0; dest_in = 4'd0; pc_in = 0; val_rn_in = 0; val_rm_in = 0;
    shift_operand_in = 12'd0; signed_imm_24_in = 24'd0;
  endtask

  initial begin
    defaults();

    // reset held two cycles with live control inputs
    rst = 0; wb_en_in = 1; s_in = 1; imm_in = 1; exe_cmd_in = 4'b0010;
    shift_operand_in = 12'h001; val_rn_in = 32'hFFFF_FFFF; dest_in = 4'd7;
    step(); step();
    chk("rst_status", {28'd0, status}, 32'h0);
    chk("rst_wb_en",  {31'd0, wb_en},  32'h0);
    chk("rst_res",    alu_res,         32'h0);

    // ADD producing zero with carry
    rst = 1;
    step();
    chk("add_zero_res", alu_res, 32'h0);
    chk("add_zero_st",  {28'd0, status}, 32'h6);

    // ADD producing signed overflow
    val_rn_in = 32'h7FFF_FFFF;
    step();
    chk("add_ovf_res", alu_res, 32'h8000_0000);
    chk("add_ovf_st",  {28'd0, status}, 32'h9);

    // CMP equal
    val_rn_in = 32'd5; shift_operand_in = 12'h005; exe_cmd_in = 4'b0100;
    step();
    chk("cmp_st", {28'd0, status}, 32'h6);

    // SBC with C=1
    shift_operand_in = 12'h003; exe_cmd_in = 4'b0101;
    step();
    chk("sbc_c1", alu_res, 32'd2);

    // clear C with 0+1, then SBC with C=0
    val_rn_in = 32'd0; shift_operand_in = 12'h001; exe_cmd_in = 4'b0010;
    step();
    val_rn_in = 32'd5; shift_operand_in = 12'h003; exe_cmd_in = 4'b0101;
    step();
    chk("sbc_c0", alu_res, 32'd1);
    chk("sbc_c0_st", {28'd0, status}, 32'h2);

    // shifter: ROR 1, ASR 4, rotated immediate
    s_in = 0; imm_in = 0; exe_cmd_in = 4'b0001;
    val_rm_in = 32'h8000_0001; shift_operand_in = 12'h0E0;
    step();
    chk("ror1", alu_res, 32'hC000_0000);
    val_rm_in = 32'h8000_0000; shift_operand_in = 12'h240;
    step();
    chk("asr4", alu_res, 32'hF800_0000);
    imm_in = 1; shift_operand_in = 12'h1FF;
    step();
    chk("imm_rot", alu_res, 32'hC000_003F);

    // freeze holds outputs and status
    freeze = 1; exe_cmd_in = 4'b0010; s_in = 1; shift_operand_in = 12'h001;
    val_rn_in = 32'hFFFF_FFFF;
    step();
    chk("frz_res", alu_res, 32'hC000_003F);
    chk("frz_st",  {28'd0, status}, 32'h2);

    // flush inserts a bubble, status holds
    freeze = 0; flush = 1; wb_en_in = 1; mem_w_en_in = 1;
    step();
    chk("fl_wb",  {31'd0, wb_en},    32'h0);
    chk("fl_mw",  {31'd0, mem_w_en}, 32'h0);
    chk("fl_st",  {28'd0, status},   32'h2);

    // reset wins over freeze
    flush = 0; freeze = 1; rst = 0;
    step();
    chk("rstfrz_res", alu_res, 32'h0);
    chk("rstfrz_st",  {28'd0, status}, 32'h0);

    // branch target in the same cycle
    defaults();
    pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFE; b_in = 1;
    #1;
    chk("br_const",  br_addr, 32'h0000_00F8);
    chk("brt_const", {31'd0, br_taken}, 32'h1);
    step();

    // STR address and store data
    val_rn_in = 32'h400; shift_operand_in = 12'h010; mem_w_en_in = 1;
    exe_cmd_in = 4'b0010; val_rm_in = 32'hABCD; dest_in = 4'd3;
    step();
    chk("str_addr", alu_res, 32'h410);
    chk("str_data", st_val, 32'hABCD);
    chk("str_mw",   {31'd0, mem_w_en}, 32'h1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 49) != 0);
      freeze      = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      wb_en_in    = 1'($urandom);
      mem_r_en_in = ($urandom_range(0, 3) == 0);
      mem_w_en_in = ($urandom_range(0, 3) == 0);
      b_in        = 1'($urandom);
      s_in        = 1'($urandom);
      imm_in      = 1'($urandom);
      exe_cmd_in  = 4'($urandom);
      dest_in     = 4'($urandom);
      pc_in       = $urandom;
      val_rn_in   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      val_rm_in   = $urandom;
      shift_operand_in = 12'($urandom);
      signed_imm_24_in = 24'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_exe_stage
`default_nettype wire
